// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: word-addressed memory access with byte-store read-modify-write
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] exmemALUout,
    input  logic [15:0] exmemRD1,
    input  logic [3:0]  exmemOP1,
    input  logic [2:0]  exmemregWrite,
    input  logic        exmemW,
    input  logic        exmemR,
    input  logic        exmemSB,
    input  logic        exmemF,
    output logic        memReq,
    output logic        memWe,
    output logic [14:0] memAddr,
    output logic [15:0] memWdata,
    input  logic [15:0] memRdata,
    input  logic        memAck,
    output logic        stall,
    output logic [15:0] memwbData,
    output logic [15:0] memwbALUout,
    output logic [3:0]  memwbOP1,
    output logic [2:0]  memwbregWrite,
    output logic        memwbF
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR_WAIT = 3'd2,
        RMW_RD  = 3'd3,
        RMW_WR  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] rdata_q;
    logic        rd_op_q;
    logic        mem_op;
    logic        ack;
    logic [15:0] merged_word;

    assign mem_op = exmemSB | exmemW | exmemR;
    // An ack only counts while a request is actually outstanding.
    assign ack    = memReq & memAck;
    // Byte lane 0 is the high byte, lane 1 the low byte of the word.
    assign merged_word = exmemALUout[0] ? {memRdata[15:8], exmemRD1[7:0]}
                                        : {exmemRD1[7:0], memRdata[7:0]};

    // Next-state decode: store-byte beats write beats read when several are set.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (exmemSB)     next_state = RMW_RD;
                else if (exmemW) next_state = WR_WAIT;
                else if (exmemR) next_state = RD_WAIT;
            end
            RD_WAIT: if (ack) next_state = DONE;
            WR_WAIT: if (ack) next_state = DONE;
            RMW_RD:  if (ack) next_state = RMW_WR;
            RMW_WR:  if (ack) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pipeline hold: asserted from decode until the access reaches DONE.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = mem_op;
            DONE:    stall = 1'b0;
            default: stall = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Memory port registers, computed from the upcoming state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= 15'h0000;
            memWdata <= 16'h0000;
        end else begin
            memReq <= (next_state inside {RD_WAIT, WR_WAIT, RMW_RD, RMW_WR});
            memWe  <= (next_state inside {WR_WAIT, RMW_WR});
            if (state == IDLE && next_state != IDLE)
                memAddr <= exmemALUout[15:1];
            if (state == IDLE && next_state == WR_WAIT)
                memWdata <= exmemRD1;
            else if (state == RMW_RD && ack)
                memWdata <= merged_word;
        end
    end

    // Read-data capture and a flag remembering that the current access is a plain read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 16'h0000;
            rd_op_q <= 1'b0;
        end else begin
            if ((state == RD_WAIT || state == RMW_RD) && ack)
                rdata_q <= memRdata;
            if (state == IDLE)
                rd_op_q <= (next_state == RD_WAIT);
        end
    end

    // MEM/WB pipeline registers advance whenever the stage is not stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memwbData     <= 16'h0000;
            memwbALUout   <= 16'h0000;
            memwbOP1      <= 4'h0;
            memwbregWrite <= 3'b000;
            memwbF        <= 1'b0;
        end else if (!stall) begin
            memwbData     <= (state == DONE && rd_op_q) ? rdata_q : 16'h0000;
            memwbALUout   <= exmemALUout;
            memwbOP1      <= exmemOP1;
            memwbregWrite <= exmemregWrite;
            memwbF        <= exmemF;
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-003 SHALL have inputs from EX/MEM: exmemALUout in 16 (byte address or result), exmemRD1 in 16 (store data), exmemOP1 in 4, exmemregWrite in 3, exmemW/exmemR/exmemSB/exmemF in 1 each.
REQ-004 SHALL have memory ports: memReq out 1, memWe out 1, memAddr out 15 (word address), memWdata out 16, memRdata in 16, memAck in 1.
REQ-005 SHALL have output stall out 1, which holds EX/MEM and upstream stages when high.
REQ-006 SHALL have registered MEM/WB outputs: memwbData out 16, memwbALUout out 16, memwbOP1 out 4, memwbregWrite out 3, memwbF out 1.

Function
REQ-007 SHALL implement states IDLE, RD_WAIT, WR_WAIT, RMW_RD, RMW_WR, DONE.
REQ-008 SHALL decode ops in IDLE with priority SB > W > R; none asserted = non-memory op.
REQ-009 SHALL drive memAddr = exmemALUout[15:1]; exmemALUout[0] = byte lane (0 -> bits[15:8], 1 -> bits[7:0]).
REQ-010 SHALL transition IDLE->RD_WAIT on R, IDLE->WR_WAIT on W, IDLE->RMW_RD on SB; non-memory op stays in IDLE.
REQ-011 SHALL register memReq; it is 1 in RD_WAIT, WR_WAIT, RMW_RD and RMW_WR, and 0 in IDLE and DONE.
REQ-012 SHALL assert memWe only in WR_WAIT and RMW_WR.
REQ-013 SHALL hold memAddr, memWe and memWdata stable while memReq=1 and memAck=0.
REQ-014 SHALL sample memAck at posedge; ack while memReq=1 advances RD_WAIT->DONE, WR_WAIT->DONE, RMW_RD->RMW_WR and RMW_WR->DONE; memAck while memReq=0 SHALL be ignored.
REQ-015 SHALL capture memRdata into an internal read register on ack in RD_WAIT and in RMW_RD.
REQ-016 SHALL in WR_WAIT drive memWdata = exmemRD1.
REQ-017 SHALL in RMW_WR drive memWdata = captured word with the selected lane replaced by exmemRD1[7:0]; the other lane is unchanged.
REQ-018 SHALL go DONE->IDLE unconditionally after one cycle.
REQ-019 SHALL drive stall combinationally: 1 in IDLE when a memory op is decoded, 1 in every wait/RMW state, and 0 in DONE and in IDLE for a non-memory op.
REQ-020 SHALL load all memwb registers on any posedge where stall=0.
REQ-021 SHALL load memwbData = captured read word for R (DONE state) and 16'h0000 otherwise.
REQ-022 SHALL pass memwbALUout, memwbOP1, memwbregWrite and memwbF straight through from the EX/MEM inputs.
REQ-023 SHALL hold all memwb registers while stall=1.
REQ-024 SHALL give latencies with ack on the first request cycle as: R/W = 2 stall cycles followed by DONE; SB = 3 stall cycles followed by DONE; non-memory op = 0 stall cycles.
REQ-025 SHALL impose no timeout; an absent memAck holds stall=1 indefinitely.

Reset
REQ-026 SHALL, while reset=0, force state=IDLE, memReq=0, memWe=0, memAddr=0, memWdata=0, read register=0, and all memwb outputs=0.
REQ-027 SHALL, on reset asserted mid-transaction, abort immediately with memReq=0 asynchronously and issue no write; after release the unit resumes in IDLE.

Verification
REQ-028 SHALL cover: non-memory op with ALUout=16'h1234, regWrite=3'b101, F=1 -> stall=0; after 1 edge memwbALUout=16'h1234, memwbData=0, memwbregWrite=3'b101, memwbF=1.
REQ-029 SHALL cover: R at ALUout=16'h0010 with memRdata=16'hBEEF, ack 3 cycles late -> memAddr=15'h0008, stall high 5 cycles, then memwbData=16'hBEEF.
REQ-030 SHALL cover: SB at ALUout=16'h0021 with RD1=16'h00AA and memory word 16'h1234 -> RMW write of 16'h12AA to word 15'h0010; lane 0 (ALUout=16'h0020) writes 16'hAA34.
REQ-031 SHALL cover: W and R both asserted with RD1=16'h5A5A -> exactly one write request of 16'h5A5A and no read.
REQ-032 SHALL cover: reset low during RMW_WR before ack -> memReq=0 same cycle, all outputs 0, no write observed; after release a W completes normally.
REQ-033 SHALL cover: memAck pulsed while IDLE -> no state change, stall=0, memwb outputs unaffected.
